// File: rtl/aes_128_keyexp_wr_2key.sv
`default_nettype none
// ============================================================================
// Module   : aes_128_keyexp_wr_2key
// Brief    : AES-128 key expansion streaming 11 round keys to a key RAM as
//            64-bit halves, using four 1-cycle-latency S-box ROMs.
// Revision : 1.0 - initial release
// ============================================================================

module aes_sbox_bram (
    input  logic       clk,
    input  logic [7:0] addr,
    output logic [7:0] dout
);

    // Row-major forward S-box; entry x lives at bits [2047-8x -: 8].
    localparam logic [2047:0] c_sbox = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    always_ff @(posedge clk) begin
        dout <= c_sbox[{~addr, 3'b000} +: 8];
    end

endmodule

module aes_128_keyexp_wr_2key (
    input  logic         clk,
    input  logic         kill,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         wr_idle,
    output logic         en_wr,
    output logic [63:0]  key_round_wr,
    output logic         key_ready,
    output logic         busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR_HI = 3'd1,
        WR_LO = 3'd2,
        SUB   = 3'd3,
        CALC  = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t         r_state;
    logic [127:0]   r_key;
    logic [3:0]     r_round;
    logic [7:0]     r_rcon;

    logic [31:0]    w_rot;
    logic [31:0]    w_sub;
    logic [31:0]    w_t;
    logic [31:0]    w_w0;
    logic [31:0]    w_w1;
    logic [31:0]    w_w2;
    logic [31:0]    w_w3;
    logic [127:0]   w_key_next;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    // The ROMs see RotWord(w3) continuously; their output is consumed in CALC.
    assign w_rot = {r_key[23:0], r_key[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox_bram u_sbox (
            .clk  (clk),
            .addr (w_rot[8*i +: 8]),
            .dout (w_sub[8*i +: 8])
        );
    end

    assign w_t        = w_sub ^ {r_rcon, 24'h0};
    assign w_w0       = r_key[127:96] ^ w_t;
    assign w_w1       = r_key[95:64]  ^ w_w0;
    assign w_w2       = r_key[63:32]  ^ w_w1;
    assign w_w3       = r_key[31:0]   ^ w_w2;
    assign w_key_next = {w_w0, w_w1, w_w2, w_w3};

    assign busy = (r_state != IDLE);

    always_ff @(posedge clk) begin
        if (kill) begin
            r_state      <= IDLE;
            r_key        <= '0;
            r_round      <= '0;
            r_rcon       <= '0;
            en_wr        <= 1'b0;
            key_round_wr <= '0;
            key_ready    <= 1'b0;
        end else begin
            en_wr     <= 1'b0;
            key_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start && wr_idle) begin
                        r_key        <= key_in;
                        r_round      <= 4'd0;
                        r_rcon       <= 8'h01;
                        r_state      <= WR_HI;
                        en_wr        <= 1'b1;
                        key_round_wr <= key_in[127:64];
                    end
                end
                WR_HI: begin
                    r_state      <= WR_LO;
                    en_wr        <= 1'b1;
                    key_round_wr <= r_key[63:0];
                end
                WR_LO: begin
                    if (r_round == 4'd10) begin
                        r_state   <= DONE;
                        key_ready <= 1'b1;
                    end else begin
                        r_state <= SUB;
                    end
                end
                SUB: begin
                    r_state <= CALC;
                end
                CALC: begin
                    r_key        <= w_key_next;
                    r_round      <= r_round + 4'd1;
                    r_rcon       <= xtime(r_rcon);
                    r_state      <= WR_HI;
                    en_wr        <= 1'b1;
                    key_round_wr <= w_key_next[127:64];
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
